// File: rtl/pla_sweep_pkg.sv
// Shared types and constants for the PLA vector sweeper and its response checker.
package pla_sweep_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  localparam logic [31:0] SIG_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] SIG_POLY_DEF = 32'h04C1_1DB7;

  // Word-index width; never below 1 so a single-word sweep still has a legal port.
  function automatic int idx_w(input int n_in, input int word_w);
    return (n_in - $clog2(word_w) < 1) ? 1 : n_in - $clog2(word_w);
  endfunction
endpackage

// File: rtl/pla_vector_sweeper_if.sv
// Truth-table word stream: valid/ready handshake carrying one packed word and its index.
interface pla_vector_sweeper_if #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 5
);
  logic [WORD_W-1:0] word_data;
  logic [IDX_W-1:0]  word_index;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, word_index, word_valid, input word_ready);
  modport slave  (input word_data, word_index, word_valid, output word_ready);
endinterface

// File: rtl/sweep_misr.sv
// 32-bit serial-input MISR: one response bit folded in per enabled cycle.
module sweep_misr import pla_sweep_pkg::*; #(
  parameter logic [31:0] POLY = SIG_POLY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [31:0] sig
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      sig <= SIG_INIT;
    else if (clr) sig <= SIG_INIT;
    else if (en)  sig <= {sig[30:0], 1'b0} ^ ((sig[31] ^ din) ? POLY : 32'h0);
  end
endmodule

// File: rtl/pla_vector_sweeper.sv
// Exhaustive sweeper for a combinational single-output function: drives x, packs y0 into
// truth-table words, and keeps an onset count and MISR signature.
module pla_vector_sweeper import pla_sweep_pkg::*; #(
  parameter int          N_IN     = 10,
  parameter int          WORD_W   = 32,
  parameter logic [31:0] SIG_POLY = SIG_POLY_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      x,
  input  logic                 y0,
  pla_vector_sweeper_if.master wif,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN:0]        ones_count,
  output logic [31:0]          signature
);
  localparam int              LW      = $clog2(WORD_W);
  localparam int              IDX_W   = idx_w(N_IN, WORD_W);
  localparam logic [N_IN-1:0] LO_MASK = N_IN'(WORD_W - 1);
  localparam logic [N_IN-1:0] X_LAST  = '1;

  state_t            state, state_nx;
  logic [WORD_W-1:0] pack, pack_bit;
  logic              complete, stall, samp, xfer, last;

  assign xfer     = wif.word_valid & wif.word_ready;
  assign complete = (x & LO_MASK) == LO_MASK;
  // Only a word-completing sample must wait for the output register; others proceed.
  assign stall    = complete & wif.word_valid & ~wif.word_ready;
  assign samp     = (state == SWEEP) & ~stall;
  assign last     = (x == X_LAST);
  assign pack_bit = WORD_W'(y0) << (x & LO_MASK);
  assign busy     = (state == SWEEP) || (state == DRAIN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)       state_nx = SWEEP;
      SWEEP:   if (samp && last) state_nx = DRAIN;
      DRAIN:   if (xfer)        state_nx = DONE;
      DONE:                     state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x              <= '0;
      pack           <= '0;
      ones_count     <= '0;
      wif.word_data  <= '0;
      wif.word_index <= '0;
      wif.word_valid <= 1'b0;
    end else begin
      // A reload below overrides this, so completion on a transfer cycle keeps valid high.
      if (xfer) wif.word_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x          <= '0;
          pack       <= '0;
          ones_count <= '0;
        end
        SWEEP: if (samp) begin
          ones_count <= ones_count + (N_IN+1)'(y0);
          if (!last) x <= x + 1'b1;
          if (complete) begin
            wif.word_data  <= pack | pack_bit;
            wif.word_index <= IDX_W'(x >> LW);
            wif.word_valid <= 1'b1;
            pack           <= '0;
          end else begin
            pack <= pack | pack_bit;
          end
        end
        DRAIN: if (xfer) x <= '0;
        default: ;
      endcase
    end
  end

  sweep_misr #(.POLY(SIG_POLY)) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE && start),
    .en  (samp),
    .din (y0),
    .sig (signature)
  );
endmodule
